// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU operation
// encodings (also consumed by aluControl), state encodings and the
// registered control word.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation class handed to aluControl
  typedef enum logic [1:0] {
    ALUOP_LWSW  = 2'b00,
    ALUOP_BE    = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Debug-visible state numbering, RST first and then in datapath order
  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12
  } state_e;

  // Registered Moore control word; the *On* bits are qualified by live
  // inputs (memory ready, zero flag) on the way out of the controller.
  typedef struct packed {
    logic       irWriteOnReady;
    logic       pcEnOnReady;
    logic       pcEnOnZf;
    logic       pcEnAlways;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    alu_op_e    aluOp;
  } ctrl_t;

  // States that stall on the memory and are covered by the wait timer
  function automatic logic isWaitState(state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Bus between the multicycle controller and its datapath. The slave side is
// the controller; the master side is whoever owns the instruction register,
// ALU flag and memory.
interface mc_if;
  logic [5:0] i_op;
  logic       i_zf;
  logic       i_mem_ready;

  logic       o_irWrite;
  logic       o_memWrite;
  logic       o_iorD;
  logic       o_regWrite;
  logic       o_regDst;
  logic       o_memToReg;
  logic       o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [1:0] o_pcSrc;
  logic [1:0] o_aluOp;
  logic       o_pcEn;
  logic       o_illegal;
  logic       o_fault;
  logic [3:0] o_state;

  modport master (
    output i_op, i_zf, i_mem_ready,
    input  o_irWrite, o_memWrite, o_iorD, o_regWrite, o_regDst, o_memToReg,
           o_aluSrcA, o_aluSrcB, o_pcSrc, o_aluOp, o_pcEn, o_illegal,
           o_fault, o_state
  );

  modport slave (
    input  i_op, i_zf, i_mem_ready,
    output o_irWrite, o_memWrite, o_iorD, o_regWrite, o_regDst, o_memToReg,
           o_aluSrcA, o_aluSrcB, o_pcSrc, o_aluOp, o_pcEn, o_illegal,
           o_fault, o_state
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts stalled cycles in a memory wait state. o_expired is raised while
// the count sits one below TIMEOUT, i.e. the cycle that would be the
// TIMEOUT-th stalled cycle.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over counting so a fresh wait always starts from zero
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: Moore FSM with a memory wait
// timeout. Optional jump support is built when MULTICYCLE_CONTROL_JUMP_EN
// is defined; otherwise opcode 000010 decodes as illegal.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  mc_if.slave  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal;
  logic   ready;
  logic   timerEnable;
  logic   timerClear;
  logic   expired;
  logic   fault;

  assign ready = bus.i_mem_ready;

  // Control word for a given state; anything not set stays 0
  function automatic ctrl_t decodeCtrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.aluSrcB        = SRCB_FOUR;
        c.aluOp          = ALUOP_LWSW;
        c.pcSrc          = PCSRC_ALU;
        c.irWriteOnReady = 1'b1;
        c.pcEnOnReady    = 1'b1;
      end
      ST_DECODE: begin
        c.aluSrcB = SRCB_BRANCH;
        c.aluOp   = ALUOP_LWSW;
      end
      ST_MEMADR, ST_ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_LWSW;
      end
      ST_MEMRD: c.iorD = 1'b1;
      ST_MEMWB: begin
        c.memToReg = 1'b1;
        c.regWrite = 1'b1;
      end
      ST_MEMWR: begin
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
      end
      ST_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_REG;
        c.aluOp   = ALUOP_RTYPE;
      end
      ST_ALUWB: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      ST_BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = SRCB_REG;
        c.aluOp    = ALUOP_BE;
        c.pcSrc    = PCSRC_ALUOUT;
        c.pcEnOnZf = 1'b1;
      end
      ST_ADDIWB: c.regWrite = 1'b1;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      ST_JUMP: begin
        c.pcSrc      = PCSRC_JUMP;
        c.pcEnAlways = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // A wait state that stalls on its last allowed cycle faults back to FETCH;
  // a ready in that same cycle takes priority.
  assign timerEnable = isWaitState(state_q) && !ready;
  assign fault       = timerEnable && expired;
  assign timerClear  = (state_d != state_q) || fault;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_waitTimer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (timerClear),
    .i_enable  (timerEnable),
    .o_expired (expired)
  );

  // Next-state selection and illegal-opcode detection
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.i_op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OP_J:         state_d = ST_JUMP;
`else
          OP_J: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
`endif
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: state_d = (bus.i_op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD: begin
        if (ready)        state_d = ST_MEMWB;
        else if (expired) state_d = ST_FETCH;
      end
      ST_MEMWB: state_d = ST_FETCH;
      ST_MEMWR: if (ready || expired) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      ST_JUMP:   state_d = ST_FETCH;
`endif
      default:   state_d = ST_RST;
    endcase
  end

  // State and control word registered together so outputs track the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decodeCtrl(state_d);
    end
  end

  assign bus.o_irWrite  = ctrl_q.irWriteOnReady & ready;
  assign bus.o_pcEn     = ctrl_q.pcEnAlways
                        | (ctrl_q.pcEnOnReady & ready)
                        | (ctrl_q.pcEnOnZf & bus.i_zf);
  assign bus.o_memWrite = ctrl_q.memWrite;
  assign bus.o_iorD     = ctrl_q.iorD;
  assign bus.o_regWrite = ctrl_q.regWrite;
  assign bus.o_regDst   = ctrl_q.regDst;
  assign bus.o_memToReg = ctrl_q.memToReg;
  assign bus.o_aluSrcA  = ctrl_q.aluSrcA;
  assign bus.o_aluSrcB  = ctrl_q.aluSrcB;
  assign bus.o_pcSrc    = ctrl_q.pcSrc;
  assign bus.o_aluOp    = ctrl_q.aluOp;
  assign bus.o_illegal  = illegal;
  assign bus.o_fault    = fault;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Each instruction is expanded into
// its sequence of phases; every cycle's expected outputs are queued and a
// negedge monitor compares them with the DUT.
module tb_multicycle_control;

  localparam int TO = 15;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

`ifdef MULTICYCLE_CONTROL_JUMP_EN
  localparam bit JUMP_ON = 1'b1;
`else
  localparam bit JUMP_ON = 1'b0;
`endif

  localparam logic [3:0] S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
    S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP = 4'd12;

  typedef struct packed {
    logic       irW, memW, iorD, regW, regDst, memToReg, srcA;
    logic [1:0] srcB, pcSrc, aluOp;
    logic       pcEn, ill, fault;
    logic [3:0] st;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] curOp;
  logic       curZf;
  obs_t       expQ[$];
  int         tests = 0;
  int         fails = 0;
  int         cycNo = 0;

  mc_if bus();

  multicycle_control #(.TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {bus.o_irWrite, bus.o_memWrite, bus.o_iorD, bus.o_regWrite,
            bus.o_regDst, bus.o_memToReg, bus.o_aluSrcA, bus.o_aluSrcB,
            bus.o_pcSrc, bus.o_aluOp, bus.o_pcEn, bus.o_illegal,
            bus.o_fault, bus.o_state};
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h (state %0d) want %h (state %0d)",
               name, act, act.st, exp, exp.st);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      obs_t e;
      e = expQ.pop_front();
      checkOutput($sformatf("cyc%0d", cycNo), sample(), e);
      cycNo++;
    end
  end

  // One clock of stimulus plus its expected outputs
  task automatic cyc(input logic rdy, input obs_t e);
    @(posedge clk);
    #1;
    bus.i_op = curOp;
    bus.i_zf = curZf;
    bus.i_mem_ready = rdy;
    expQ.push_back(e);
  endtask

  task automatic rstHold(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQ.push_back('0);
  endtask

  // Memory wait: lowN stalled cycles then ready; stalls abort after TO cycles.
  // res: 0 completed, 1 timed out, 2 reset dropped inside the wait
  task automatic waitPhase(input logic [3:0] st, input int lowN,
                           input int rstAt, output int res);
    obs_t e;
    for (int i = 0; i < TO; i++) begin
      e = '0;
      e.st = st;
      if (st == S_FETCH) e.srcB = 2'b01;
      else e.iorD = 1'b1;
      if (st == S_MEMWR) e.memW = 1'b1;
      if (i == rstAt) begin
        @(posedge clk);
        #1;
        bus.i_mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mid_wait", sample(), '0);
        res = 2;
        return;
      end
      if (i >= lowN) begin
        if (st == S_FETCH) begin
          e.irW = 1'b1;
          e.pcEn = 1'b1;
        end
        cyc(1'b1, e);
        res = 0;
        return;
      end
      e.fault = (i == TO - 1);
      cyc(1'b0, e);
      if (e.fault) begin
        res = 1;
        return;
      end
    end
    res = 1;
  endtask

  // Expand one instruction into its phases and queue every cycle
  task automatic applyStimulus(input logic [5:0] op, input logic zf,
                               input int fetchWait, input int memWait,
                               input int rstAt);
    obs_t e;
    int   res;
    logic legal;
    logic isMem;
    curOp = op;
    curZf = zf;
    waitPhase(S_FETCH, fetchWait, -1, res);
    if (res != 0) return;
    isMem = (op == LW) || (op == SW);
    legal = isMem || op == RT || op == BEQ || op == ADDI || (op == JMP && JUMP_ON);
    e = '0; e.st = S_DECODE; e.srcB = 2'b11; e.ill = !legal;
    cyc(1'($urandom_range(0, 1)), e);
    if (!legal) return;
    e = '0;
    if (isMem) begin
      e.st = S_MEMADR; e.srcA = 1'b1; e.srcB = 2'b10;
      cyc(1'($urandom_range(0, 1)), e);
      if (op == LW) begin
        waitPhase(S_MEMRD, memWait, -1, res);
        if (res == 0) begin
          e = '0; e.st = S_MEMWB; e.memToReg = 1'b1; e.regW = 1'b1;
          cyc(1'($urandom_range(0, 1)), e);
        end
      end else begin
        waitPhase(S_MEMWR, memWait, rstAt, res);
        if (res == 2) rstHold(2);
      end
    end else if (op == RT) begin
      e.st = S_EXEC; e.srcA = 1'b1; e.aluOp = 2'b10;
      cyc(1'($urandom_range(0, 1)), e);
      e = '0; e.st = S_ALUWB; e.regDst = 1'b1; e.regW = 1'b1;
      cyc(1'($urandom_range(0, 1)), e);
    end else if (op == BEQ) begin
      e.st = S_BRANCH; e.srcA = 1'b1; e.aluOp = 2'b01; e.pcSrc = 2'b01; e.pcEn = zf;
      cyc(1'($urandom_range(0, 1)), e);
    end else if (op == ADDI) begin
      e.st = S_ADDIEX; e.srcA = 1'b1; e.srcB = 2'b10;
      cyc(1'($urandom_range(0, 1)), e);
      e = '0; e.st = S_ADDIWB; e.regW = 1'b1;
      cyc(1'($urandom_range(0, 1)), e);
    end else begin
      e.st = S_JUMP; e.pcSrc = 2'b10; e.pcEn = 1'b1;
      cyc(1'($urandom_range(0, 1)), e);
    end
  endtask

  function automatic int randWait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 2);
    if (r < 9) return $urandom_range(3, TO - 1);
    return TO + $urandom_range(0, 3);
  endfunction

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    curOp = '0;
    curZf = 1'b0;
    bus.i_op = '0;
    bus.i_zf = 1'b0;
    bus.i_mem_ready = 1'b0;

    rstHold(3);

    applyStimulus(RT, 1'b0, 0, 0, -1);
    applyStimulus(LW, 1'b0, 0, 3, -1);
    applyStimulus(BEQ, 1'b1, 0, 0, -1);
    applyStimulus(BEQ, 1'b0, 1, 0, -1);
    applyStimulus(SW, 1'b0, 0, TO + 5, -1);
    applyStimulus(6'b111111, 1'b0, 0, 0, -1);
    applyStimulus(JMP, 1'b1, 0, 0, -1);
    applyStimulus(ADDI, 1'b0, 2, 0, -1);
    applyStimulus(LW, 1'b0, 0, TO - 1, -1);
    applyStimulus(RT, 1'b0, TO + 1, 0, -1);
    applyStimulus(SW, 1'b0, 1, TO + 5, 4);
    applyStimulus(SW, 1'b1, 0, 2, -1);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        default: op = 6'($urandom);
      endcase
      applyStimulus(op, 1'($urandom_range(0, 1)), randWait(), randWait(), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL queue_drain: got %0d pending want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles a wait state holds with i_mem_ready low.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_op  input  6  opcode from instruction register.
REQ-005 SHALL have port i_zf  input  1  ALU zero flag.
REQ-006 SHALL have port i_mem_ready  input  1  memory access complete this cycle.
REQ-007 SHALL have ports o_irWrite, o_memWrite, o_iorD, o_regWrite, o_regDst, o_memToReg, o_aluSrcA, each output 1, for datapath control.
REQ-008 SHALL have ports o_aluSrcB, o_pcSrc, o_aluOp, each output 2; o_aluOp is consumed by aluControl: 00 LWSW, 01 BE, 10 RTYPE.
REQ-009 SHALL have port o_pcEn  output  1  PC load enable.
REQ-010 SHALL have ports o_illegal, o_fault, each output 1, as one-cycle pulses; o_state  output  4  is the current state for debug.

Function
REQ-011 SHALL be a Moore FSM with states RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; unlisted outputs are 0 in every state.
REQ-012 RST SHALL drive all outputs 0 and go to FETCH unconditionally.
REQ-013 FETCH SHALL drive iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00; irWrite=pcEn=1 only in the cycle i_mem_ready=1; then DECODE, else hold.
REQ-014 DECODE SHALL drive aluSrcA=0, aluSrcB=11, aluOp=00; next state by i_op: 100011/101011 MEMADR, 000000 EXEC, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP; any other opcode gives o_illegal=1 and returns to FETCH.
REQ-015 MEMADR SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00; lw goes to MEMRD, sw to MEMWR.
REQ-016 MEMRD SHALL drive iorD=1 and hold until i_mem_ready, then go to MEMWB; MEMWB SHALL drive regDst=0, memToReg=1, regWrite=1, then FETCH.
REQ-017 MEMWR SHALL drive iorD=1 and memWrite=1 while holding, and go to FETCH in the cycle i_mem_ready=1.
REQ-018 EXEC SHALL drive aluSrcA=1, aluSrcB=00, aluOp=10, then ALUWB; ALUWB SHALL drive regDst=1, memToReg=0, regWrite=1, then FETCH.
REQ-019 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcEn=i_zf, then FETCH.
REQ-020 ADDIEX SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00, then ADDIWB; ADDIWB SHALL drive regDst=0, memToReg=0, regWrite=1, then FETCH.
REQ-021 JUMP SHALL drive pcSrc=10, pcEn=1, then FETCH.
REQ-022 The wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each held cycle with i_mem_ready=0.
REQ-023 On reaching TIMEOUT, the FSM SHALL pulse o_fault one cycle and go to FETCH with the counter cleared; i_mem_ready=1 in that same cycle takes priority, giving no fault.
REQ-024 o_state SHALL encode RST=0, FETCH=1, then ascending in the REQ-011 order.

Reset
REQ-025 Asserting i_rst_n=0 at any time, including mid-wait, SHALL immediately force state RST, counter 0, and all outputs 0.
REQ-026 The first rising edge after deassertion SHALL move the FSM to FETCH.

Configuration
REQ-027 With MULTICYCLE_CONTROL_JUMP_EN defined, opcode 000010 SHALL go to JUMP; without it, JUMP logic SHALL be absent and 000010 SHALL be illegal per REQ-014.

Structure
REQ-028 Opcodes, aluOp encodings (shared with aluControl), and state encodings SHALL live in the shared package mc_pkg.
REQ-029 The timeout counter SHALL be the sub-module mc_wait_timer, with clear, enable, and expired signals.

Verification
REQ-030 Reset released, i_op=000000, ready=1 -> states RST,FETCH,DECODE,EXEC,ALUWB,FETCH, with aluOp=10 in EXEC and regWrite=1 only in ALUWB.
REQ-031 lw (100011) with ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with memToReg=1.
REQ-032 beq (000100) with i_zf=1, then again with i_zf=0 -> pcEn=1 then 0 in BRANCH, and pcSrc=01 both times.
REQ-033 sw with ready stuck 0, TIMEOUT=15 -> memWrite held 15 cycles, o_fault one pulse, FETCH next.
REQ-034 i_op=111111 -> o_illegal one pulse in DECODE, FETCH next; 000010 -> JUMP only if MULTICYCLE_CONTROL_JUMP_EN is defined.
REQ-035 i_rst_n dropped during MEMWR -> outputs 0 immediately, memWrite=0, o_state=0.
